// File: rtl/regsr_bank_if.sv
// regsr_bank bus: read ports, live write port, save/restore
// control and the shadow-bank debug read port.
interface regsr_bank_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 2,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] iw_read_addr;
  logic [NUM_RD*DATA_W-1:0] ow_read_data;
  logic [ADDR_W-1:0]        iw_write_addr;
  logic [DATA_W-1:0]        iw_write_data;
  logic                     iw_write_enable;
  logic                     ow_write_ready;
  logic                     iw_save;
  logic                     iw_restore;
  logic                     ow_busy;
  logic                     ow_done;
  logic [ADDR_W-1:0]        iw_shadow_addr;
  logic [DATA_W-1:0]        ow_shadow_data;

  modport master (
    output iw_read_addr,
    input  ow_read_data,
    output iw_write_addr,
    output iw_write_data,
    output iw_write_enable,
    input  ow_write_ready,
    output iw_save,
    output iw_restore,
    input  ow_busy,
    input  ow_done,
    output iw_shadow_addr,
    input  ow_shadow_data
  );

  modport slave (
    input  iw_read_addr,
    output ow_read_data,
    input  iw_write_addr,
    input  iw_write_data,
    input  iw_write_enable,
    output ow_write_ready,
    input  iw_save,
    input  iw_restore,
    output ow_busy,
    output ow_done,
    input  iw_shadow_addr,
    output ow_shadow_data
  );
endinterface

// File: rtl/regsr_bank.sv
// Special-register file with shadow bank and a one-entry-per-cycle
// save/restore sequencer used on trap entry and return.
module regsr_bank #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 2,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 0
) (
  input logic         iw_clk,
  input logic         iw_rst,
  regsr_bank_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    SAVE,
    RESTORE
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              done_q;
  logic [DATA_W-1:0] live_q   [DEPTH];
  logic [DATA_W-1:0] shadow_q [DEPTH];

  logic                     wr_ready;
  logic                     wr_fire;
  logic [NUM_RD*DATA_W-1:0] rd_data_d;

  assign wr_ready = (state_q == IDLE);
  assign wr_fire  = bus.iw_write_enable
                  & wr_ready;

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // write lands before a same-cycle save starts copying
          if (bus.iw_write_enable)
            live_q[bus.iw_write_addr] <= bus.iw_write_data;
          idx_q <= '0;
          if (bus.iw_save)
            state_q <= SAVE;
          else if (bus.iw_restore)
            state_q <= RESTORE;
        end
        SAVE: begin
          shadow_q[idx_q] <= live_q[idx_q];
          idx_q <= idx_q + ADDR_W'(1);
          if (&idx_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        RESTORE: begin
          live_q[idx_q] <= shadow_q[idx_q];
          idx_q <= idx_q + ADDR_W'(1);
          if (&idx_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if ((BYPASS != 0) && wr_fire &&
          (bus.iw_read_addr[p*ADDR_W +: ADDR_W]
           == bus.iw_write_addr))
        rd_data_d[p*DATA_W +: DATA_W] = bus.iw_write_data;
      else
        rd_data_d[p*DATA_W +: DATA_W] =
          live_q[bus.iw_read_addr[p*ADDR_W +: ADDR_W]];
    end
  end

  assign bus.ow_read_data   = rd_data_d;
  assign bus.ow_write_ready = wr_ready;
  assign bus.ow_busy        = ~wr_ready;
  assign bus.ow_done        = done_q;
  assign bus.ow_shadow_data = shadow_q[bus.iw_shadow_addr];
endmodule

// File: tb/tb_regsr_bank.sv
// Directed bench for regsr_bank: two instances (no bypass / bypass)
// share one stimulus stream.
module tb_regsr_bank;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regsr_bank_if #(.DATA_W(24), .ADDR_W(2), .NUM_RD(2)) bus0 ();
  regsr_bank_if #(.DATA_W(24), .ADDR_W(2), .NUM_RD(2)) bus1 ();

  assign bus1.iw_read_addr    = bus0.iw_read_addr;
  assign bus1.iw_write_addr   = bus0.iw_write_addr;
  assign bus1.iw_write_data   = bus0.iw_write_data;
  assign bus1.iw_write_enable = bus0.iw_write_enable;
  assign bus1.iw_save         = bus0.iw_save;
  assign bus1.iw_restore      = bus0.iw_restore;
  assign bus1.iw_shadow_addr  = bus0.iw_shadow_addr;

  regsr_bank #(
    .DATA_W(24), .ADDR_W(2), .NUM_RD(2), .BYPASS(0)
  ) u_dut0 (
    .iw_clk(clk),
    .iw_rst(rst),
    .bus   (bus0)
  );

  regsr_bank #(
    .DATA_W(24), .ADDR_W(2), .NUM_RD(2), .BYPASS(1)
  ) u_dut1 (
    .iw_clk(clk),
    .iw_rst(rst),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] rd0(input int p);
    return bus0.ow_read_data[p*24 +: 24];
  endfunction

  function automatic logic [23:0] rd1(input int p);
    return bus1.ow_read_data[p*24 +: 24];
  endfunction

  task automatic set_ra(input logic [1:0] a0,
                        input logic [1:0] a1);
    bus0.iw_read_addr = {a1, a0};
    #1;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [23:0] d);
    bus0.iw_write_addr   = a;
    bus0.iw_write_data   = d;
    bus0.iw_write_enable = 1'b1;
    tick();
    bus0.iw_write_enable = 1'b0;
  endtask

  task automatic sh_rd(input string tag,
                       input logic [1:0] a,
                       input logic [23:0] exp);
    bus0.iw_shadow_addr = a;
    #1;
    chk(tag, 32'(bus0.ow_shadow_data), 32'(exp));
  endtask

  task automatic lv_rd(input string tag,
                       input logic [1:0] a,
                       input logic [23:0] exp);
    set_ra(a, a);
    chk(tag, 32'(rd0(0)), 32'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [23:0] vals [4];

  initial begin
    checks   = 0;
    failures = 0;
    vals[0] = 24'h000011;
    vals[1] = 24'h000022;
    vals[2] = 24'h000033;
    vals[3] = 24'h000044;
    rst = 1'b1;
    bus0.iw_read_addr    = '0;
    bus0.iw_write_addr   = '0;
    bus0.iw_write_data   = '0;
    bus0.iw_write_enable = 1'b0;
    bus0.iw_save         = 1'b0;
    bus0.iw_restore      = 1'b0;
    bus0.iw_shadow_addr  = 2'd3;
    #2;
    chk("rst_busy", 32'(bus0.ow_busy), 32'd0);
    chk("rst_done", 32'(bus0.ow_done), 32'd0);
    chk("rst_ready", 32'(bus0.ow_write_ready), 32'd1);
    chk("rst_rd0", 32'(rd0(0)), 32'd0);
    chk("rst_shadow", 32'(bus0.ow_shadow_data), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) wr(2'(i), vals[i]);
    for (int i = 0; i < 4; i++) begin
      set_ra(2'(i), 2'(3 - i));
      chk("wr_p0", 32'(rd0(0)), 32'(vals[i]));
      chk("wr_p1", 32'(rd0(1)), 32'(vals[3 - i]));
    end

    do_reset();
    set_ra(2'd3, 2'd0);
    chk("rerst_e3", 32'(rd0(0)), 32'd0);
    chk("rerst_e0", 32'(rd0(1)), 32'd0);
    chk("rerst_b1", 32'(rd1(0)), 32'd0);

    for (int i = 0; i < 4; i++) wr(2'(i), vals[i]);
    set_ra(2'd2, 2'd1);
    bus0.iw_write_addr   = 2'd2;
    bus0.iw_write_data   = 24'hABCDEF;
    bus0.iw_write_enable = 1'b1;
    #1;
    chk("nobyp_old", 32'(rd0(0)), 32'h000033);
    chk("byp_new", 32'(rd1(0)), 32'hABCDEF);
    chk("byp_other", 32'(rd1(1)), 32'h000022);
    tick();
    bus0.iw_write_enable = 1'b0;
    #1;
    chk("wr_commit", 32'(rd0(0)), 32'hABCDEF);
    wr(2'd2, 24'h000033);

    bus0.iw_save = 1'b1;
    #1;
    chk("sv_c0_busy", 32'(bus0.ow_busy), 32'd0);
    tick();
    bus0.iw_save = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("sv_busy", 32'(bus0.ow_busy), 32'd1);
      chk("sv_ready", 32'(bus0.ow_write_ready), 32'd0);
      chk("sv_done_lo", 32'(bus0.ow_done), 32'd0);
      bus0.iw_write_addr   = 2'd0;
      bus0.iw_write_data   = 24'h000999;
      bus0.iw_write_enable = (c == 2);
      tick();
    end
    bus0.iw_write_enable = 1'b0;
    chk("sv_done", 32'(bus0.ow_done), 32'd1);
    chk("sv_idle", 32'(bus0.ow_busy), 32'd0);
    chk("sv_rdy_back", 32'(bus0.ow_write_ready), 32'd1);
    tick();
    chk("sv_done_1cyc", 32'(bus0.ow_done), 32'd0);
    for (int i = 0; i < 4; i++) sh_rd("sv_shadow", 2'(i), vals[i]);
    lv_rd("sv_drop", 2'd0, 24'h000011);

    for (int i = 0; i < 4; i++) wr(2'(i), 24'h0);
    lv_rd("zeroed", 2'd3, 24'h0);
    bus0.iw_restore = 1'b1;
    tick();
    bus0.iw_restore = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk("rs_busy", 32'(bus0.ow_busy), 32'd1);
      bus0.iw_save = (c == 2);
      if (c == 3) begin
        lv_rd("rs_part1", 2'd1, 24'h000022);
        lv_rd("rs_part2", 2'd2, 24'h000000);
      end
      tick();
    end
    bus0.iw_save = 1'b0;
    chk("rs_done", 32'(bus0.ow_done), 32'd1);
    tick();
    chk("rs_sv_ignored", 32'(bus0.ow_busy), 32'd0);
    for (int i = 0; i < 4; i++) lv_rd("rs_live", 2'(i), vals[i]);

    wr(2'd0, 24'hAA0001);
    bus0.iw_save    = 1'b1;
    bus0.iw_restore = 1'b1;
    tick();
    bus0.iw_save    = 1'b0;
    bus0.iw_restore = 1'b0;
    for (int c = 1; c <= 4; c++) tick();
    chk("both_done", 32'(bus0.ow_done), 32'd1);
    sh_rd("both_sh0", 2'd0, 24'hAA0001);
    lv_rd("both_lv0", 2'd0, 24'hAA0001);
    lv_rd("both_lv1", 2'd1, 24'h000022);

    bus0.iw_save = 1'b1;
    tick();
    bus0.iw_save = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("ab_busy", 32'(bus0.ow_busy), 32'd0);
    chk("ab_ready", 32'(bus0.ow_write_ready), 32'd1);
    chk("ab_done", 32'(bus0.ow_done), 32'd0);
    lv_rd("ab_live0", 2'd0, 24'h0);
    lv_rd("ab_live3", 2'd3, 24'h0);
    sh_rd("ab_sh0", 2'd0, 24'h0);
    sh_rd("ab_sh1", 2'd1, 24'h0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("ab_nodone", 32'(bus0.ow_done), 32'd0);
      chk("ab_nobusy", 32'(bus0.ow_busy), 32'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/regsr_bank.md
# regsr_bank

Parametrised special-register file with configurable width, depth and read-port count, an optional write-to-read bypass, and a shadow bank. A save/restore sequencer copies the whole file between the live and shadow banks one entry per cycle. It sits in the execute stage beside the GP register file and supplies SR operands. Trap/interrupt entry uses save; return uses restore.

## Interface
Parameters:
- DATA_W, 24, register width in bits
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of combinational read ports
- BYPASS, 0, 1 = read of the address being written this cycle returns the write data

Ports:
- iw_clk  in  1  clock, rising edge
- iw_rst  in  1  reset: asynchronous, active-high
- iw_read_addr  in  NUM_RD*ADDR_W  packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- ow_read_data  out  NUM_RD*DATA_W  packed read data; port p uses bits [p*DATA_W +: DATA_W]
- iw_write_addr  in  ADDR_W  live-bank write address
- iw_write_data  in  DATA_W  write data
- iw_write_enable  in  1  write request
- ow_write_ready  out  1  write accepted when high; low while sequencer busy
- iw_save  in  1  one-cycle pulse: copy live to shadow
- iw_restore  in  1  one-cycle pulse: copy shadow to live
- ow_busy  out  1  sequencer active
- ow_done  out  1  one-cycle pulse when a save/restore completes
- iw_shadow_addr  in  ADDR_W  debug read address into the shadow bank
- ow_shadow_data  out  DATA_W  combinational shadow-bank read data

## Operation
- Storage: live[DEPTH], shadow[DEPTH], each DATA_W bits. Reset clears all entries of both banks to 0, including the last entry.
- Reads are combinational from the live bank.
- With BYPASS=1, when write_enable && write_ready && read_addr==write_addr, that port returns iw_write_data.
- A write occurs at the clock edge when iw_write_enable && ow_write_ready.
- ow_write_ready = (state == IDLE). Writes requested while busy are dropped. The requester must hold the request until ready.
- FSM states: IDLE, SAVE, RESTORE. Index counter idx is ADDR_W bits.
  - IDLE: iw_save moves to SAVE; else iw_restore moves to RESTORE. In both cases idx <= 0. Save has priority if both are asserted.
  - SAVE: each cycle, shadow[idx] <= live[idx] and idx <= idx+1. When idx == DEPTH-1, the state returns to IDLE after that copy.
  - RESTORE: same sequence with live[idx] <= shadow[idx].
- iw_save and iw_restore are ignored while not in IDLE.
- ow_busy = (state != IDLE).
- ow_done is registered. It is high for exactly the one cycle after the last copy, which is the first IDLE cycle.
- During RESTORE, the read ports return the partially restored live bank. Consumers stall on ow_busy.
- A write accepted in the same IDLE cycle as iw_save is committed before the copy, so the save captures it.
- idx wraps naturally. No other arithmetic is involved.

## Timing
- Read latency is 0 cycles (combinational). Write latency is 1 edge.
- Save/restore pulse sampled in cycle 0:
  - ow_busy is high in cycles 1..DEPTH.
  - Entry k is copied at the edge ending cycle k+1.
  - ow_done and ow_write_ready are high in cycle DEPTH+1.
- A new save or restore can be accepted in cycle DEPTH+1, the same cycle ow_done is high.
- Reset values: ow_busy=0, ow_done=0, ow_write_ready=1, all ow_read_data=0, ow_shadow_data=0, state=IDLE, idx=0.
- Reset asserted mid-sequence aborts it immediately, clears both banks, and suppresses ow_done.

## Test plan
- Reset, then write live[0..3]=24'h000011/22/33/44 and read through both ports. Expect those values; after a new reset all reads return 0, including entry 3.
- Write live[2]=24'hABCDEF with BYPASS=1 and read_addr0=2 in the same cycle. Expect ow_read_data port0=24'hABCDEF before the edge. With BYPASS=0, expect the old value.
- Pulse iw_save with live={11,22,33,44}:
  - Expect ow_busy high for exactly 4 cycles and ow_done high in cycle 5.
  - Expect shadow[0..3]=11/22/33/44 via ow_shadow_data.
  - Expect writes during busy to be dropped (ow_write_ready=0).
- Overwrite live with 0s, then pulse iw_restore. Expect live={11,22,33,44} after 4 busy cycles. Expect iw_save pulsed mid-restore to be ignored.
- Assert iw_save and iw_restore together in IDLE. Expect SAVE, with the shadow updated and live unchanged.
- Assert iw_rst during cycle 2 of SAVE. Expect ow_busy=0 immediately, no ow_done pulse, both banks 0, and ow_write_ready=1.
